// File: rtl/apb_pkg.sv
// Shared types for the two-port APB round-robin master.
// Holds the FSM state encoding, the default bus widths and the latched request record.
package apb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-port round-robin arbiter: combinational grant, registered last-grant pointer.
// The pointer starts at port 1 so that port 0 wins the first tie after reset.
module apb_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_en,
    output logic [1:0] o_ready
);

    logic       r_last;
    logic [1:0] w_grant;

    // On a tie the port that was not served last wins.
    always_comb begin
        w_grant = i_valid;
        if (i_valid == 2'b11) begin
            w_grant = r_last ? 2'b01 : 2'b10;
        end
    end

    assign o_ready = i_en ? w_grant : 2'b00;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (|o_ready) begin
            r_last <= o_ready[1];
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// wait-state handling and a timeout that aborts transfers the slave never completes.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic              r_psel, w_psel_nxt;
    logic              r_penable, w_penable_nxt;
    logic              r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
    logic              r_port, w_port_nxt;
    logic [7:0]        r_wait, w_wait_nxt;
    logic [1:0]        r_rsp_valid, w_rsp_valid_nxt;
    logic [1:0]        r_rsp_err, w_rsp_err_nxt;
    logic [DATA_W-1:0] r_rsp_rdata [2];
    logic [DATA_W-1:0] w_rsp_rdata_nxt [2];

    logic              w_win;
    logic [1:0]        w_ready;
    logic              w_accept;
    req_t              w_req0, w_req1, w_gnt_req;
    logic [DATA_W-1:0] w_read_data;

    assign w_win = (r_state == IDLE) || ((r_state == ACCESS) && pready);

    apb_rr_arb2 u_arb (
        .i_clk   (pclk),
        .i_rst   (preset),
        .i_valid ({req1_valid, req0_valid}),
        .i_en    (w_win),
        .o_ready (w_ready)
    );

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign w_accept   = |w_ready;

    assign w_req0    = '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
    assign w_req1    = '{write: req1_write, addr: req1_addr, wdata: req1_wdata};
    assign w_gnt_req = w_ready[1] ? w_req1 : w_req0;

    assign w_read_data = (!r_pwrite && !pslverr) ? prdata : '0;

    // Next-state and next-output logic; an accept overrides the completion path so
    // a back-to-back transfer keeps psel high and goes straight to SETUP.
    always_comb begin
        w_state_nxt        = r_state;
        w_psel_nxt         = r_psel;
        w_penable_nxt      = r_penable;
        w_pwrite_nxt       = r_pwrite;
        w_paddr_nxt        = r_paddr;
        w_pwdata_nxt       = r_pwdata;
        w_port_nxt         = r_port;
        w_wait_nxt         = r_wait;
        w_rsp_valid_nxt    = 2'b00;
        w_rsp_err_nxt      = 2'b00;
        w_rsp_rdata_nxt[0] = '0;
        w_rsp_rdata_nxt[1] = '0;

        unique case (r_state)
            IDLE: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_wait_nxt    = 8'd0;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    w_rsp_valid_nxt[r_port] = 1'b1;
                    w_rsp_err_nxt[r_port]   = pslverr;
                    w_rsp_rdata_nxt[r_port] = w_read_data;
                    w_psel_nxt              = 1'b0;
                    w_penable_nxt           = 1'b0;
                    w_state_nxt             = IDLE;
                end else if (r_wait == LAST_WAIT) begin
                    w_rsp_valid_nxt[r_port] = 1'b1;
                    w_rsp_err_nxt[r_port]   = 1'b1;
                    w_psel_nxt              = 1'b0;
                    w_penable_nxt           = 1'b0;
                    w_state_nxt             = IDLE;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            default: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase

        if (w_accept) begin
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_pwrite_nxt  = w_gnt_req.write;
            w_paddr_nxt   = w_gnt_req.addr;
            w_pwdata_nxt  = w_gnt_req.wdata;
            w_port_nxt    = w_ready[1];
            w_state_nxt   = SETUP;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state        <= IDLE;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_pwrite       <= 1'b0;
            r_paddr        <= '0;
            r_pwdata       <= '0;
            r_port         <= 1'b0;
            r_wait         <= 8'd0;
            r_rsp_valid    <= 2'b00;
            r_rsp_err      <= 2'b00;
            r_rsp_rdata[0] <= '0;
            r_rsp_rdata[1] <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_psel         <= w_psel_nxt;
            r_penable      <= w_penable_nxt;
            r_pwrite       <= w_pwrite_nxt;
            r_paddr        <= w_paddr_nxt;
            r_pwdata       <= w_pwdata_nxt;
            r_port         <= w_port_nxt;
            r_wait         <= w_wait_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_err      <= w_rsp_err_nxt;
            r_rsp_rdata[0] <= w_rsp_rdata_nxt[0];
            r_rsp_rdata[1] <= w_rsp_rdata_nxt[1];
        end
    end

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_err   = r_rsp_err[0];
    assign rsp1_err   = r_rsp_err[1];
    assign rsp0_rdata = r_rsp_rdata[0];
    assign rsp1_rdata = r_rsp_rdata[1];

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: a scripted APB register slave, a transaction-level
// reference model (memory array plus queues), directed vectors and random traffic.
module tb_apb_rr_master;

    localparam int TIMEOUT = 15;

    logic       pclk = 1'b0;
    logic       preset;
    logic       req0_valid, req0_ready, req0_write;
    logic [3:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid, rsp0_err;
    logic [7:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_write;
    logic [3:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid, rsp1_err;
    logic [7:0] rsp1_rdata;
    logic [3:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pwrite, psel, penable, pready, pslverr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int waits;
        bit err;
    } plan_t;

    typedef struct {
        int         port;
        bit         write;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         cyc;
    } acc_t;

    typedef struct {
        int         port;
        bit         write;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         waits;
        bit         err;
        logic [7:0] expRdata;
        bit         expErr;
    } vec_t;

    plan_t      forcedPlanQ[$];
    plan_t      planLog[$];
    acc_t       reqQ[$];
    bit         randomPlans = 1'b0;
    int         lastAcc = 1;
    logic [7:0] slaveMem [16];
    logic [7:0] modelMem [16];

    apb_rr_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic plan_t nextPlan();
        plan_t p;
        int    r;
        p = '{0, 1'b0};
        if (forcedPlanQ.size() > 0) begin
            p = forcedPlanQ.pop_front();
        end else if (randomPlans) begin
            r = $urandom_range(0, 9);
            if (r >= 6 && r < 8) p.waits = $urandom_range(1, 3);
            if (r == 8) p.waits = TIMEOUT - 1 + $urandom_range(0, 1);
            p.err = (r == 9) || ($urandom_range(0, 7) == 0);
        end
        return p;
    endfunction

    // APB slave: each transfer follows a plan (wait cycles, error flag); outside
    // ACCESS the slave drives noise on pready/pslverr/prdata, which must be ignored.
    plan_t curPlan = '{0, 1'b0};
    int    accCnt = 0;
    always @(posedge pclk) begin
        #1;
        if (psel === 1'b1 && penable === 1'b0) begin
            curPlan = nextPlan();
            planLog.push_back(curPlan);
            accCnt  = 0;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = 8'($urandom);
        end else if (psel === 1'b1 && penable === 1'b1) begin
            pready  = (accCnt >= curPlan.waits);
            pslverr = pready ? curPlan.err : 1'($urandom);
            prdata  = (pready && !pwrite) ? slaveMem[paddr] : 8'($urandom);
            if (pready && pwrite && !curPlan.err) slaveMem[paddr] = pwdata;
            accCnt++;
        end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = 8'($urandom);
        end
    end

    // Reference model: every accept is queued; every response pops the oldest
    // accept and is judged from the memory array and the slave plan it ran under.
    always @(negedge pclk) begin : monitor
        acc_t       a;
        plan_t      p;
        bit         tOut, eErr;
        logic [7:0] eData;
        int         port, eLat;
        if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
            checkOutput("rsp_one_port", 32'(rsp0_valid & rsp1_valid), 0);
            if (reqQ.size() == 0 || planLog.size() == 0) begin
                checkOutput("rsp_unexpected", 1, 0);
            end else begin
                a     = reqQ.pop_front();
                p     = planLog.pop_front();
                tOut  = (p.waits >= TIMEOUT);
                eErr  = tOut || p.err;
                eData = 8'h00;
                if (!eErr) begin
                    if (a.write) modelMem[a.addr] = a.wdata;
                    else eData = modelMem[a.addr];
                end
                eLat = tOut ? TIMEOUT + 2 : p.waits + 3;
                port = (rsp1_valid === 1'b1) ? 1 : 0;
                checkOutput("rsp_port", port, a.port);
                checkOutput("rsp_rdata", port ? rsp1_rdata : rsp0_rdata, eData);
                checkOutput("rsp_err", port ? rsp1_err : rsp0_err, 32'(eErr));
                checkOutput("rsp_latency", cyc - a.cyc, eLat);
            end
        end
        if (preset === 1'b1) begin
            reqQ.delete();
            planLog.delete();
            lastAcc = 1;
        end else if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            checkOutput("ready_onehot", 32'(req0_ready & req1_ready), 0);
            checkOutput("ready_needs_valid",
                        32'((req0_ready & !req0_valid) | (req1_ready & !req1_valid)), 0);
            port = (req1_ready === 1'b1) ? 1 : 0;
            if (req0_valid && req1_valid) checkOutput("rr_tie_winner", port, 1 - lastAcc);
            lastAcc = port;
            if (port == 0) reqQ.push_back('{0, req0_write, req0_addr, req0_wdata, cyc});
            else           reqQ.push_back('{1, req1_write, req1_addr, req1_wdata, cyc});
        end
    end

    task automatic setReq(input int port, input bit v, input bit wr, input logic [3:0] a, input logic [7:0] d);
        if (port == 0) begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Presents one request and holds it until accepted; fields are scrambled afterwards.
    task automatic applyStimulus(input int port, input bit wr, input logic [3:0] a, input logic [7:0] d);
        bit got = 1'b0;
        @(posedge pclk); #1;
        setReq(port, 1'b1, wr, a, d);
        for (int i = 0; i < 300; i++) begin
            @(negedge pclk);
            if ((port == 0 ? req0_ready : req1_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
        @(posedge pclk); #1;
        setReq(port, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
    endtask

    task automatic waitRsp(input int port, output logic [7:0] rd, output logic er);
        bit got = 1'b0;
        rd = 8'hxx;
        er = 1'bx;
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if ((port == 0 ? rsp0_valid : rsp1_valid) === 1'b1) begin
                rd  = port ? rsp1_rdata : rsp0_rdata;
                er  = port ? rsp1_err : rsp0_err;
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("rsp_timeout", 0, 1);
    endtask

    task automatic doReset();
        @(posedge pclk); #1;
        preset = 1'b1;
        setReq(0, 1'b0, 1'b0, 4'h0, 8'h00);
        setReq(1, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
    endtask

    vec_t       vecs [10];
    logic [7:0] rd;
    logic       er;
    int         enCnt, pselDrops, nAcc, rspCnt;
    bit         stable;
    logic       pselAtRsp;
    int         accPort [4];
    int         accCyc [4];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        foreach (slaveMem[i]) begin
            slaveMem[i] = 8'h00;
            modelMem[i] = 8'h00;
        end
        vecs[0] = '{0, 1'b0, 4'h3, 8'h00,  0,          1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1, 1'b1, 4'h5, 8'h5A,  2,          1'b0, 8'h00, 1'b0};
        vecs[2] = '{1, 1'b0, 4'h5, 8'h00,  0,          1'b0, 8'h5A, 1'b0};
        vecs[3] = '{0, 1'b1, 4'h5, 8'h77,  1,          1'b1, 8'h00, 1'b1};
        vecs[4] = '{0, 1'b0, 4'h5, 8'h00,  3,          1'b0, 8'h5A, 1'b0};
        vecs[5] = '{1, 1'b1, 4'hF, 8'hFF,  TIMEOUT-1,  1'b0, 8'h00, 1'b0};
        vecs[6] = '{1, 1'b0, 4'hF, 8'h00,  0,          1'b0, 8'hFF, 1'b0};
        vecs[7] = '{0, 1'b1, 4'h0, 8'hC3,  TIMEOUT,    1'b0, 8'h00, 1'b1};
        vecs[8] = '{0, 1'b0, 4'h0, 8'h00,  0,          1'b0, 8'h00, 1'b0};
        vecs[9] = '{1, 1'b0, 4'hF, 8'h00,  0,          1'b1, 8'h00, 1'b1};

        preset = 1'b1;
        setReq(0, 1'b0, 1'b0, 4'h0, 8'h00);
        setReq(1, 1'b0, 1'b0, 4'h0, 8'h00);
        pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
        repeat (2) @(negedge pclk);
        checkOutput("reset_psel", psel, 0);
        checkOutput("reset_penable", penable, 0);
        checkOutput("reset_pwrite", pwrite, 0);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_pwdata", pwdata, 0);
        checkOutput("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        checkOutput("reset_rsp_rdata", {rsp1_rdata, rsp0_rdata}, 0);
        checkOutput("reset_rsp_err", {rsp1_err, rsp0_err}, 0);
        @(posedge pclk); #1 preset = 1'b0;

        // Zero-wait write, phase by phase.
        @(posedge pclk); #1;
        setReq(0, 1'b1, 1'b1, 4'h3, 8'hA5);
        @(negedge pclk);
        checkOutput("wr_ready_c0", req0_ready, 1);
        @(posedge pclk); #1;
        setReq(0, 1'b0, 1'b0, 4'h9, 8'h00);
        @(negedge pclk);
        checkOutput("wr_setup_c1", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b0, 1'b1, 4'h3, 8'hA5});
        @(negedge pclk);
        checkOutput("wr_access_c2", {psel, penable, paddr, pwdata}, {1'b1, 1'b1, 4'h3, 8'hA5});
        @(negedge pclk);
        checkOutput("wr_rsp_c3", {rsp0_valid, rsp0_err, psel, penable}, {1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge pclk);
        checkOutput("wr_rsp_one_cycle", rsp0_valid, 0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            forcedPlanQ.push_back('{vecs[i].waits, vecs[i].err});
            applyStimulus(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].wdata);
            waitRsp(vecs[i].port, rd, er);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_err", i), er, vecs[i].expErr);
        end

        // Three wait states: penable high for four cycles with stable address/data.
        forcedPlanQ.push_back('{3, 1'b0});
        applyStimulus(0, 1'b1, 4'h7, 8'h3C);
        enCnt = 0; stable = 1'b1; er = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (penable === 1'b1) begin
                enCnt++;
                if (paddr !== 4'h7 || pwdata !== 8'h3C || pwrite !== 1'b1 || psel !== 1'b1) stable = 1'b0;
            end
            if (rsp0_valid === 1'b1) begin
                er = rsp0_err;
                break;
            end
        end
        checkOutput("wait_penable_cycles", enCnt, 4);
        checkOutput("wait_bus_stable", stable, 1);
        checkOutput("wait_rsp_err", er, 0);

        // Slave error on a read of a location holding nonzero data.
        forcedPlanQ.push_back('{0, 1'b1});
        applyStimulus(1, 1'b0, 4'h5, 8'h00);
        waitRsp(1, rd, er);
        checkOutput("slverr_err", er, 1);
        checkOutput("slverr_rdata", rd, 8'h00);

        // Timeout: pready stuck low.
        forcedPlanQ.push_back('{100, 1'b0});
        applyStimulus(0, 1'b0, 4'h3, 8'h00);
        enCnt = 0; er = 1'bx; rd = 8'hxx; pselAtRsp = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            if (penable === 1'b1) enCnt++;
            if (rsp0_valid === 1'b1) begin
                er = rsp0_err; rd = rsp0_rdata; pselAtRsp = psel;
                break;
            end
        end
        checkOutput("timeout_access_cycles", enCnt, TIMEOUT);
        checkOutput("timeout_err", er, 1);
        checkOutput("timeout_rdata", rd, 8'h00);
        checkOutput("timeout_psel", pselAtRsp, 0);
        applyStimulus(0, 1'b0, 4'h3, 8'h00);
        waitRsp(0, rd, er);
        checkOutput("after_timeout_rdata", rd, 8'hA5);
        checkOutput("after_timeout_err", er, 0);

        // Reset during ACCESS drops the transfer and the round-robin pointer.
        forcedPlanQ.push_back('{100, 1'b0});
        applyStimulus(0, 1'b0, 4'h4, 8'h00);
        repeat (3) @(negedge pclk);
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0;
        @(negedge pclk);
        checkOutput("rst_mid_bus", {psel, penable, paddr}, 0);
        checkOutput("rst_mid_rsp", {rsp1_valid, rsp0_valid}, 0);
        rspCnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge pclk);
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) rspCnt++;
        end
        checkOutput("rst_mid_no_rsp", rspCnt, 0);
        @(posedge pclk); #1;
        setReq(0, 1'b1, 1'b0, 4'h1, 8'h00);
        setReq(1, 1'b1, 1'b0, 4'h2, 8'h00);
        @(negedge pclk);
        checkOutput("rst_tie_ready", {req1_ready, req0_ready}, 2'b01);
        @(posedge pclk); #1;
        setReq(0, 1'b0, 1'b0, 4'h0, 8'h00);
        waitRsp(1, rd, er);
        checkOutput("rst_tie_second_err", er, 0);
        @(posedge pclk); #1;
        setReq(1, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (6) @(negedge pclk);

        // Both ports valid from reset and holding: alternate, back to back.
        doReset();
        @(posedge pclk); #1;
        setReq(0, 1'b1, 1'b1, 4'h1, 8'h11);
        setReq(1, 1'b1, 1'b1, 4'h2, 8'h22);
        nAcc = 0; pselDrops = 0;
        for (int i = 0; i < 60 && nAcc < 4; i++) begin
            @(negedge pclk);
            if (nAcc > 0 && psel !== 1'b1) pselDrops++;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                accPort[nAcc] = (req1_ready === 1'b1) ? 1 : 0;
                accCyc[nAcc]  = cyc;
                nAcc++;
                if (nAcc == 4) begin
                    @(posedge pclk); #1;
                    setReq(0, 1'b0, 1'b0, 4'h0, 8'h00);
                    setReq(1, 1'b0, 1'b0, 4'h0, 8'h00);
                end
            end
        end
        checkOutput("arb_accepts", nAcc, 4);
        checkOutput("arb_order", {accPort[0][1:0], accPort[1][1:0], accPort[2][1:0], accPort[3][1:0]},
                    8'b00_01_00_01);
        checkOutput("arb_spacing", {accCyc[1] - accCyc[0], accCyc[2] - accCyc[1], accCyc[3] - accCyc[2]},
                    {32'd2, 32'd2, 32'd2});
        checkOutput("arb_psel_held", pselDrops, 0);
        repeat (8) @(negedge pclk);

        // Random traffic from both ports with random slave behaviour.
        randomPlans = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge pclk);
                    applyStimulus(0, 1'($urandom), 4'($urandom), 8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge pclk);
                    applyStimulus(1, 1'($urandom), 4'($urandom), 8'($urandom));
                end
            end
        join
        repeat (60) @(negedge pclk);
        randomPlans = 1'b0;
        checkOutput("drain_outstanding", reqQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
